icache_refill_ctrl: RTL and testbench

Refill controller sitting directly downstream of `icache_top`'s miss-request port (`downstream_txreq_*`) and upstream of its refill-data port (`downstream_rxdat_*`). Accepts line-miss requests, issues line-aligned reads to the memory bus, and collects `BEATS` narrow response beats into one full cache line. Returns each completed line with its originating MSHR entry id. Responses are in order; up to `OST_NUM` requests may be outstanding.

---
 rtl/toy_pack.sv | 16 +
 rtl/icache_refill_id_fifo.sv | 66 ++++++
 rtl/icache_refill_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_pack.sv
// Shared constants and types for the instruction-cache refill controller.
package toy_pack;

    localparam int ICACHE_REFILL_BEATS   = 4;
    localparam int ICACHE_REFILL_BEAT_W  = 128;
    localparam int ICACHE_REFILL_OST_NUM = 4;
    localparam int ICACHE_REFILL_ID_W    = 4;
    localparam int ICACHE_REFILL_LINE_W  = ICACHE_REFILL_BEATS * ICACHE_REFILL_BEAT_W;

    // One completed refill line together with the MSHR entry it belongs to.
    typedef struct packed {
        logic [ICACHE_REFILL_LINE_W-1:0] data;
        logic [ICACHE_REFILL_ID_W-1:0]   entry_id;
    } refill_line_t;

endpackage

// File: rtl/icache_refill_id_fifo.sv
// Synchronous FIFO of outstanding MSHR entry ids. DEPTH must be a power of two
// so that the read/write pointers wrap naturally.
module icache_refill_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: accepts line misses, issues
// line-aligned memory reads, assembles BEATS response beats into a line and
// returns it with the originating MSHR entry id. Responses are in order.
// Optional feature macro: ICACHE_REFILL_TIMEOUT_EN adds a response watchdog
// driving timeout_err; without it timeout_err is tied low.
module icache_refill_ctrl
    import toy_pack::*;
#(
    parameter int ADDR_W      = 32,
    parameter int ID_W        = ICACHE_REFILL_ID_W,
    parameter int BEAT_W      = ICACHE_REFILL_BEAT_W,
    parameter int BEATS       = ICACHE_REFILL_BEATS,
    parameter int OST_NUM     = ICACHE_REFILL_OST_NUM,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    txreq_vld,
    output logic                    txreq_rdy,
    input  logic [ADDR_W-1:0]       txreq_addr,
    input  logic [ID_W-1:0]         txreq_entry_id,
    output logic                    mem_req_vld,
    input  logic                    mem_req_rdy,
    output logic [ADDR_W-1:0]       mem_req_addr,
    input  logic                    mem_rsp_vld,
    output logic                    mem_rsp_rdy,
    input  logic [BEAT_W-1:0]       mem_rsp_data,
    input  logic                    mem_rsp_last,
    output logic                    rxdat_vld,
    input  logic                    rxdat_rdy,
    output logic [BEAT_W*BEATS-1:0] rxdat_data,
    output logic [ID_W-1:0]         rxdat_entry_id,
    output logic                    proto_err,
    output logic                    timeout_err,
    output logic                    busy
);

    localparam int LINE_W = BEAT_W * BEATS;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    if (OST_NUM < 1 || (OST_NUM & (OST_NUM - 1)) != 0) begin : g_bad_ost
        $error("OST_NUM must be a power of two");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC must fit in 16 bits");
    end

    logic              fifo_full, fifo_empty;
    logic [ID_W-1:0]   fifo_head;
    logic              txreq_hs, rsp_hs, rx_hs;

    logic              mem_req_vld_q, mem_req_vld_d;
    logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              line_vld_q, line_vld_d;
    logic              proto_err_q, proto_err_d;

    // Low address bits are discarded by line alignment.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^txreq_addr[OFF_W-1:0];

    // A new miss needs a free id slot and a free (or draining) request register.
    assign txreq_rdy   = !rst && !fifo_full && (!mem_req_vld_q || mem_req_rdy);
    // A pending line blocks further beats until the icache takes it.
    assign mem_rsp_rdy = !rst && !line_vld_q;
    assign txreq_hs    = txreq_vld && txreq_rdy;
    assign rsp_hs      = mem_rsp_vld && mem_rsp_rdy;
    assign rx_hs       = line_vld_q && rxdat_rdy;

    icache_refill_id_fifo #(
        .DEPTH (OST_NUM),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (txreq_hs),
        .push_data (txreq_entry_id),
        .pop       (rx_hs),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Request register, beat assembly and protocol checking.
    always_comb begin
        mem_req_vld_d  = mem_req_vld_q;
        mem_req_addr_d = mem_req_addr_q;
        line_d         = line_q;
        cnt_d          = cnt_q;
        line_vld_d     = line_vld_q;
        proto_err_d    = proto_err_q;

        if (txreq_hs) begin
            mem_req_vld_d  = 1'b1;
            mem_req_addr_d = {txreq_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end else if (mem_req_rdy) begin
            mem_req_vld_d  = 1'b0;
        end

        if (rx_hs) begin
            line_vld_d = 1'b0;
        end

        if (rsp_hs) begin
            if (fifo_empty) begin
                // Nobody is waiting for this beat: drop it and flag.
                proto_err_d = 1'b1;
            end else begin
                line_d[int'(cnt_q)*BEAT_W +: BEAT_W] = mem_rsp_data;
                // Completion is by count; the last flag is only cross-checked.
                if (cnt_q == LAST_CNT) begin
                    cnt_d      = '0;
                    line_vld_d = 1'b1;
                    if (!mem_rsp_last) proto_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (mem_rsp_last) proto_err_d = 1'b1;
                end
            end
        end
    end

    // State registers for the request path and line assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_vld_q  <= 1'b0;
            mem_req_addr_q <= '0;
            line_q         <= '0;
            cnt_q          <= '0;
            line_vld_q     <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            mem_req_vld_q  <= mem_req_vld_d;
            mem_req_addr_q <= mem_req_addr_d;
            line_q         <= line_d;
            cnt_q          <= cnt_d;
            line_vld_q     <= line_vld_d;
            proto_err_q    <= proto_err_d;
        end
    end

`ifdef ICACHE_REFILL_TIMEOUT_EN
    localparam logic [15:0] WDOG_LIM = 16'(TIMEOUT_CYC);

    logic [15:0] wdog_q, wdog_d;
    logic        timeout_err_q, timeout_err_d;

    // Count cycles spent waiting on beats; saturate at the limit.
    always_comb begin
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        if (rsp_hs || fifo_empty) begin
            wdog_d = '0;
        end else if (!line_vld_q && wdog_q != WDOG_LIM) begin
            wdog_d = wdog_q + 16'd1;
        end
        if (wdog_d == WDOG_LIM) begin
            timeout_err_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign mem_req_vld    = mem_req_vld_q;
    assign mem_req_addr   = mem_req_addr_q;
    assign rxdat_vld      = line_vld_q;
    assign rxdat_data     = line_q;
    assign rxdat_entry_id = fifo_head;
    assign proto_err      = proto_err_q;
    assign busy           = !fifo_empty || line_vld_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl with a transaction-level reference
// model built from queues of outstanding ids, pending requests and beats.
module tb_icache_refill_ctrl;
    import toy_pack::*;

    localparam int ADDR_W      = 32;
    localparam int ID_W        = 4;
    localparam int BEAT_W      = 128;
    localparam int BEATS       = 4;
    localparam int OST_NUM     = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int LINE_W      = BEAT_W * BEATS;

    logic              clk;
    logic              rst;
    logic              txreq_vld, txreq_rdy;
    logic [ADDR_W-1:0] txreq_addr;
    logic [ID_W-1:0]   txreq_entry_id;
    logic              mem_req_vld, mem_req_rdy;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_vld, mem_rsp_rdy;
    logic [BEAT_W-1:0] mem_rsp_data;
    logic              mem_rsp_last;
    logic              rxdat_vld, rxdat_rdy;
    logic [LINE_W-1:0] rxdat_data;
    logic [ID_W-1:0]   rxdat_entry_id;
    logic              proto_err, timeout_err, busy;

    icache_refill_ctrl #(
        .ADDR_W      (ADDR_W),
        .ID_W        (ID_W),
        .BEAT_W      (BEAT_W),
        .BEATS       (BEATS),
        .OST_NUM     (OST_NUM),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .txreq_vld      (txreq_vld),
        .txreq_rdy      (txreq_rdy),
        .txreq_addr     (txreq_addr),
        .txreq_entry_id (txreq_entry_id),
        .mem_req_vld    (mem_req_vld),
        .mem_req_rdy    (mem_req_rdy),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_vld    (mem_rsp_vld),
        .mem_rsp_rdy    (mem_rsp_rdy),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_last   (mem_rsp_last),
        .rxdat_vld      (rxdat_vld),
        .rxdat_rdy      (rxdat_rdy),
        .rxdat_data     (rxdat_data),
        .rxdat_entry_id (rxdat_entry_id),
        .proto_err      (proto_err),
        .timeout_err    (timeout_err),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Reference model state
    int unsigned       m_ids[$];
    logic [ADDR_W-1:0] m_mreq[$];
    logic [BEAT_W-1:0] m_beats[$];
    bit                m_pend;
    refill_line_t      m_line;
    bit                m_perr;
    bit                m_terr;
    int                m_wd;

    task automatic model_clear();
        m_ids.delete();
        m_mreq.delete();
        m_beats.delete();
        m_pend = 0;
        m_line = '0;
        m_perr = 0;
        m_terr = 0;
        m_wd   = 0;
    endtask

    // Inputs are set at the falling edge; outputs are compared 1 time unit
    // later, then the model advances on the rising edge.
    task automatic cycle();
        bit exp_txrdy, txhs, mhs, rsphs, rxhs, empty_pre, pend_pre;
        #1;
        if (rst) begin
            check("txreq_rdy_in_rst", txreq_rdy, 1'b0);
            check("mem_rsp_rdy_in_rst", mem_rsp_rdy, 1'b0);
            @(posedge clk);
            model_clear();
        end else begin
            exp_txrdy = (m_ids.size() < OST_NUM) && (m_mreq.size() == 0 || mem_req_rdy);
            check("txreq_rdy", txreq_rdy, exp_txrdy);
            check("mem_req_vld", mem_req_vld, m_mreq.size() != 0);
            if (m_mreq.size() != 0) check("mem_req_addr", mem_req_addr, m_mreq[0]);
            check("mem_rsp_rdy", mem_rsp_rdy, !m_pend);
            check("rxdat_vld", rxdat_vld, m_pend);
            if (m_pend) begin
                check("rxdat_data", rxdat_data, m_line.data);
                check("rxdat_entry_id", rxdat_entry_id, m_line.entry_id);
            end
            check("proto_err", proto_err, m_perr);
            check("timeout_err", timeout_err, m_terr);
            check("busy", busy, (m_ids.size() != 0) || m_pend);

            txhs      = txreq_vld && exp_txrdy;
            mhs       = (m_mreq.size() != 0) && mem_req_rdy;
            rsphs     = mem_rsp_vld && !m_pend;
            rxhs      = m_pend && rxdat_rdy;
            empty_pre = (m_ids.size() == 0);
            pend_pre  = m_pend;
            @(posedge clk);
`ifdef ICACHE_REFILL_TIMEOUT_EN
            if (rsphs || empty_pre) m_wd = 0;
            else if (!pend_pre) m_wd++;
            if (m_wd >= TIMEOUT_CYC) m_terr = 1;
`endif
            if (rsphs) begin
                if (empty_pre) begin
                    m_perr = 1;
                end else begin
                    if ((m_beats.size() == BEATS - 1) != mem_rsp_last) m_perr = 1;
                    m_beats.push_back(mem_rsp_data);
                    if (m_beats.size() == BEATS) begin
                        for (int i = 0; i < BEATS; i++)
                            m_line.data[i*BEAT_W +: BEAT_W] = m_beats[i];
                        m_line.entry_id = ID_W'(m_ids[0]);
                        m_beats.delete();
                        m_pend = 1;
                    end
                end
            end
            if (rxhs) begin
                m_pend = 0;
                void'(m_ids.pop_front());
            end
            if (mhs) void'(m_mreq.pop_front());
            if (txhs) begin
                m_ids.push_back(int'(txreq_entry_id));
                m_mreq.push_back(txreq_addr & ~ADDR_W'(LINE_W / 8 - 1));
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        txreq_vld      = 0;
        txreq_addr     = '0;
        txreq_entry_id = '0;
        mem_req_rdy    = 0;
        mem_rsp_vld    = 0;
        mem_rsp_data   = '0;
        mem_rsp_last   = 0;
        rxdat_rdy      = 0;
    endtask

    task automatic check_reset_vals();
        check("rst_txreq_rdy", txreq_rdy, 1'b0);
        check("rst_mem_req_vld", mem_req_vld, 1'b0);
        check("rst_mem_req_addr", mem_req_addr, '0);
        check("rst_mem_rsp_rdy", mem_rsp_rdy, 1'b0);
        check("rst_rxdat_vld", rxdat_vld, 1'b0);
        check("rst_rxdat_data", rxdat_data, '0);
        check("rst_rxdat_id", rxdat_entry_id, '0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_busy", busy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        cycle();
        check_reset_vals();
        rst = 0;
        #1;
        check("post_rst_txreq_rdy", txreq_rdy, 1'b1);
        check("post_rst_mem_rsp_rdy", mem_rsp_rdy, 1'b1);
    endtask

    task automatic send_beat(input logic [BEAT_W-1:0] d, input bit last);
        mem_rsp_vld  = 1;
        mem_rsp_data = d;
        mem_rsp_last = last;
        cycle();
        mem_rsp_vld  = 0;
    endtask

    // Return every outstanding line with well-formed beats.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            txreq_vld    = 0;
            mem_req_rdy  = 1;
            rxdat_rdy    = 1;
            mem_rsp_vld  = (m_ids.size() != 0);
            mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
            mem_rsp_last = (m_beats.size() == BEATS - 1);
            cycle();
        end
    endtask

    task automatic drive_random(input int err_pct);
        txreq_vld      = ($urandom_range(0, 99) < 50);
        txreq_addr     = $urandom;
        txreq_entry_id = ID_W'($urandom_range(0, 15));
        mem_req_rdy    = ($urandom_range(0, 99) < 70);
        mem_rsp_vld    = (m_ids.size() != 0) ? ($urandom_range(0, 99) < 70)
                                             : ($urandom_range(0, 99) < err_pct);
        mem_rsp_data   = {$urandom, $urandom, $urandom, $urandom};
        mem_rsp_last   = (m_beats.size() == BEATS - 1);
        if ($urandom_range(0, 99) < err_pct) mem_rsp_last = !mem_rsp_last;
        rxdat_rdy      = ($urandom_range(0, 99) < 60);
    endtask

    logic [LINE_W-1:0] exp_line;

    initial begin
        rst = 1;
        idle_inputs();
        model_clear();
        do_reset();

        // Single miss, fixed data
        txreq_vld = 1; txreq_addr = 32'h0000_1234; txreq_entry_id = 4'd3;
        cycle();
        txreq_vld = 0;
        check("single_req_vld", mem_req_vld, 1'b1);
        check("single_req_addr", mem_req_addr, 32'h0000_1200);
        mem_req_rdy = 1;
        for (int b = 0; b < BEATS; b++) send_beat(BEAT_W'(4'hA + b), b == BEATS - 1);
        exp_line = {128'hD, 128'hC, 128'hB, 128'hA};
        check("single_rx_vld", rxdat_vld, 1'b1);
        check("single_rx_data", rxdat_data, exp_line);
        check("single_rx_id", rxdat_entry_id, 4'd3);
        rxdat_rdy = 1;
        cycle();
        rxdat_rdy = 0;

        // Four misses while the memory request port is stalled
        mem_req_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            txreq_vld = 1; txreq_addr = 32'(i * 64 + 5); txreq_entry_id = ID_W'(i);
            cycle();
        end
        check("stall_block", txreq_rdy, 1'b0);
        mem_req_rdy = 1;
        for (int i = 0; i < 8; i++) begin
            txreq_vld = 1; txreq_addr = 32'(32'h100 + i * 64); txreq_entry_id = ID_W'(4 + i);
            cycle();
        end
        check("full_block", txreq_rdy, 1'b0);

        // Hold the completed line while beats keep being offered
        for (int b = 0; b < BEATS; b++) send_beat({$urandom, $urandom, $urandom, $urandom}, b == BEATS - 1);
        for (int i = 0; i < 10; i++) begin
            mem_rsp_vld = 1; mem_rsp_last = 0; mem_rsp_data = BEAT_W'(i);
            cycle();
        end
        check("hold_rsp_rdy", mem_rsp_rdy, 1'b0);
        check("hold_rx_vld", rxdat_vld, 1'b1);
        rxdat_rdy = 1;
        cycle();
        rxdat_rdy = 0;
        check("release_rsp_rdy", mem_rsp_rdy, 1'b1);
        cycle();
        drain(200);

        // One miss, no response: watchdog behaviour
        txreq_vld = 1; txreq_addr = 32'h0000_8000; txreq_entry_id = 4'd7;
        cycle();
        txreq_vld = 0;
        for (int i = 0; i < 20; i++) cycle();
`ifdef ICACHE_REFILL_TIMEOUT_EN
        check("timeout_rise", timeout_err, 1'b1);
`else
        check("timeout_tied", timeout_err, 1'b0);
`endif
        do_reset();

        // Early last flag, then a beat with nothing outstanding
        txreq_vld = 1; txreq_addr = 32'h0000_2040; txreq_entry_id = 4'd2; mem_req_rdy = 1;
        cycle();
        txreq_vld = 0;
        for (int b = 0; b < BEATS; b++) send_beat(BEAT_W'(b + 1), b == 1);
        check("early_last_perr", proto_err, 1'b1);
        check("early_last_done", rxdat_vld, 1'b1);
        rxdat_rdy = 1;
        cycle();
        rxdat_rdy = 0;
        do_reset();
        send_beat(BEAT_W'(16'hDEAD), 1'b0);
        check("empty_beat_perr", proto_err, 1'b1);
        check("empty_beat_busy", busy, 1'b0);
        cycle();

        // Reset in the middle of a line, then a clean miss
        do_reset();
        txreq_vld = 1; txreq_addr = 32'h0000_3000; txreq_entry_id = 4'd5; mem_req_rdy = 1;
        cycle();
        txreq_vld = 0;
        send_beat(BEAT_W'(1), 1'b0);
        send_beat(BEAT_W'(2), 1'b0);
        do_reset();
        txreq_vld = 1; txreq_addr = 32'h0000_4010; txreq_entry_id = 4'd9; mem_req_rdy = 1;
        cycle();
        txreq_vld = 0;
        for (int b = 0; b < BEATS; b++) send_beat(BEAT_W'(8'h20 + b), b == BEATS - 1);
        exp_line = {128'h23, 128'h22, 128'h21, 128'h20};
        check("fresh_rx_data", rxdat_data, exp_line);
        check("fresh_rx_id", rxdat_entry_id, 4'd9);
        check("fresh_perr", proto_err, 1'b0);
        rxdat_rdy = 1;
        cycle();
        rxdat_rdy = 0;

        // Random traffic: clean, then with protocol errors
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            drive_random(0);
            cycle();
        end
        drain(100);
        for (int i = 0; i < 1000; i++) begin
            drive_random(5);
            cycle();
        end
        drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
